// File: rtl/security_pkg.sv
// Shared encodings for the security timer: FSM state codes, keypad codes
// and the timer geometry (100 centi-ticks per second).
package security_pkg;

  typedef enum logic [2:0] {
    DISARMED  = 3'b000,
    EXIT_DLY  = 3'b001,
    ARMED     = 3'b010,
    ENTRY_DLY = 3'b011,
    ALARM_ST  = 3'b100
  } state_t;

  localparam logic [1:0] KEY_ARM    = 2'b11;
  localparam logic [1:0] KEY_DISARM = 2'b00;

  localparam int         TICKS_PER_SEC = 100;
  localparam logic [6:0] CENTI_MAX     = 7'(TICKS_PER_SEC - 1);

  // States in which the shared timer runs and SEC_LEFT is shown.
  function automatic logic is_delay(state_t s);
    return (s == EXIT_DLY) || (s == ENTRY_DLY) || (s == ALARM_ST);
  endfunction

endpackage

// File: rtl/security_timer_ctrl_tick_gen.sv
// Free-running 10 ms tick divider; TICK is high for the one cycle the
// counter reads TICK_DIV-1.
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  output logic TICK
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST)              cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign TICK = (cnt == LAST);

endmodule

// File: rtl/security_timer_ctrl.sv
// Alarm-panel sequencer: exit/entry/siren delays on one shared sec/centi
// timer, zone latching and registered display/siren outputs.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   DISARMED  | idle, timer and zones cleared, waits for arm
//   EXIT_DLY  | leave-the-house delay, sensors ignored
//   ARMED     | watching sensors, timer frozen
//   ENTRY_DLY | zone tripped, waiting for disarm code
//   ALARM_ST  | siren on until disarm or siren timeout
module security_timer_ctrl
  import security_pkg::*;
#(
  parameter int CLK_FREQ  = 125_000_000,
  parameter int TICK_DIV  = CLK_FREQ / 100,
  parameter int EXIT_SEC  = 10,
  parameter int ENTRY_SEC = 5,
  parameter int ALARM_SEC = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] KEY,
  input  logic [1:0] SENSOR,
  output logic [2:0] STATE,
  output logic       ALARM,
  output logic [3:0] SEC_LEFT,
  output logic [1:0] ZONE,
  output logic       TICK_10MS
);

  localparam logic [3:0] EXIT_LD  = 4'(EXIT_SEC);
  localparam logic [3:0] ENTRY_LD = 4'(ENTRY_SEC);
  localparam logic [3:0] ALARM_LD = 4'(ALARM_SEC);

  logic       tick;
  logic       expire;
  state_t     state, st_nx;
  logic [3:0] sec_cnt, sec_nx;
  logic [6:0] centi_cnt, centi_nx;
  logic [1:0] zone, zone_nx;
  logic       alarm_q;
  logic [3:0] sec_left_q;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .CLK  (CLK),
    .RST  (RST),
    .TICK (tick)
  );

  // Last tick of the last second: a load of N expires after N*100 ticks.
  assign expire = tick && (centi_cnt == 7'd0) && (sec_cnt == 4'd1);

  always_comb begin
    st_nx    = state;
    zone_nx  = zone;
    sec_nx   = sec_cnt;
    centi_nx = centi_cnt;

    if (tick && is_delay(state)) begin
      if (centi_cnt == 7'd0) begin
        centi_nx = CENTI_MAX;
        sec_nx   = sec_cnt - 4'd1;
      end else begin
        centi_nx = centi_cnt - 7'd1;
      end
    end

    case (state)
      DISARMED: begin
        if (KEY == KEY_ARM) begin
          st_nx    = EXIT_DLY;
          sec_nx   = EXIT_LD;
          centi_nx = CENTI_MAX;
        end
      end
      EXIT_DLY: begin
        if (KEY == KEY_DISARM) st_nx = DISARMED;
        else if (expire)       st_nx = ARMED;
      end
      ARMED: begin
        if (SENSOR != 2'b00) begin
          st_nx    = ENTRY_DLY;
          sec_nx   = ENTRY_LD;
          centi_nx = CENTI_MAX;
          zone_nx  = SENSOR;
        end else if (KEY == KEY_DISARM) begin
          st_nx = DISARMED;
        end
      end
      ENTRY_DLY: begin
        zone_nx = zone | SENSOR;
        if (expire) begin
          st_nx    = ALARM_ST;
          sec_nx   = ALARM_LD;
          centi_nx = CENTI_MAX;
        end else if (KEY == KEY_DISARM) begin
          st_nx = DISARMED;
        end
      end
      ALARM_ST: begin
        if (KEY == KEY_DISARM) st_nx = DISARMED;
        else if (expire)       st_nx = ARMED;
      end
      default: st_nx = DISARMED;
    endcase

    // Any path into DISARMED wipes zones and timer.
    if (st_nx == DISARMED) begin
      zone_nx  = '0;
      sec_nx   = '0;
      centi_nx = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= DISARMED;
      sec_cnt    <= '0;
      centi_cnt  <= '0;
      zone       <= '0;
      alarm_q    <= 1'b0;
      sec_left_q <= '0;
    end else begin
      state      <= st_nx;
      sec_cnt    <= sec_nx;
      centi_cnt  <= centi_nx;
      zone       <= zone_nx;
      alarm_q    <= (st_nx == ALARM_ST);
      sec_left_q <= is_delay(st_nx) ? sec_nx : 4'd0;
    end
  end

  assign STATE     = state;
  assign ALARM     = alarm_q;
  assign SEC_LEFT  = sec_left_q;
  assign ZONE      = zone;
  assign TICK_10MS = tick;

endmodule

// File: doc/security_timer_ctrl.md
SECURITY_TIMER_CTRL -- requirements
Module: security_timer_ctrl

Interface
REQ-001 Parameter CLK_FREQ, default 125_000_000, SHALL set the input clock frequency in Hz.
REQ-002 Parameter TICK_DIV, default CLK_FREQ/100, SHALL set the clock cycles per 10 ms tick; legal range is 2 or more.
REQ-003 Parameters EXIT_SEC (default 10), ENTRY_SEC (default 5) and ALARM_SEC (default 15) SHALL set the delay lengths in seconds; legal range is 1..15.
REQ-004 CLK  in  1  SHALL be the single clock; all logic is on its rising edge.
REQ-005 RST  in  1  SHALL be the reset, which is synchronous and active-high.
REQ-006 KEY  in  2  SHALL be the user code: 2'b11 = arm, 2'b00 = disarm, other values = no action.
REQ-007 SENSOR  in  2  SHALL be the zone trip inputs, one bit per zone, active-high, synchronous to CLK.
REQ-008 STATE  out  3  SHALL be the registered current state code.
REQ-009 ALARM  out  1  SHALL be the registered siren drive.
REQ-010 SEC_LEFT  out  4  SHALL be the registered remaining whole seconds of the active delay, intended for the 7-segment display.
REQ-011 ZONE  out  2  SHALL be the registered latched set of tripped zones.
REQ-012 TICK_10MS  out  1  SHALL be a one-cycle pulse every TICK_DIV cycles, intended for display refresh.

Function
REQ-013 The tick divider SHALL count 0..TICK_DIV-1, free-running, and pulse TICK_10MS on the cycle it reads TICK_DIV-1; it SHALL NOT restart on state entry, so the first second may be short by up to one tick.
REQ-014 States SHALL be DISARMED = 3'b000, EXIT_DLY = 3'b001, ARMED = 3'b010, ENTRY_DLY = 3'b011, ALARM_ST = 3'b100; unused codes SHALL go to DISARMED on the next edge.
REQ-015 The shared timer SHALL consist of sec_cnt (4 bits) and centi_cnt (7 bits, 0..99); loading N SHALL set sec_cnt = N and centi_cnt = 99.
REQ-016 On each tick, the timer SHALL behave as follows: if centi_cnt = 0, then centi_cnt becomes 99 and sec_cnt decrements; otherwise centi_cnt decrements.
REQ-017 Expire SHALL be defined as tick AND centi_cnt = 0 AND sec_cnt = 1, so a delay of N ends after exactly N*100 ticks.
REQ-018 In DISARMED: KEY = 11 SHALL go to EXIT_DLY and load EXIT_SEC.
REQ-019 In EXIT_DLY: KEY = 00 SHALL go to DISARMED; otherwise expire SHALL go to ARMED; SENSOR SHALL be ignored.
REQ-020 In ARMED: SENSOR != 00 SHALL go to ENTRY_DLY, load ENTRY_SEC and set ZONE = SENSOR; otherwise KEY = 00 SHALL go to DISARMED; sensor has priority when both occur.
REQ-021 In ENTRY_DLY: expire SHALL go to ALARM_ST and load ALARM_SEC, with expire taking priority over a same-cycle KEY = 00; otherwise KEY = 00 SHALL go to DISARMED.
REQ-022 In ENTRY_DLY, ZONE SHALL be updated each cycle to ZONE | SENSOR.
REQ-023 In ALARM_ST: KEY = 00 SHALL go to DISARMED; otherwise expire SHALL go to ARMED (siren timeout with re-arm), and ZONE SHALL be held.
REQ-024 Every state change SHALL take effect on the edge following the cycle in which its condition is sampled (one-cycle latency).
REQ-025 ALARM SHALL be 1 exactly while STATE = ALARM_ST.
REQ-026 SEC_LEFT SHALL equal sec_cnt in EXIT_DLY, ENTRY_DLY and ALARM_ST, and 0 otherwise.
REQ-027 Entering DISARMED SHALL clear ZONE and the timer.
REQ-028 The timer SHALL NOT decrement in DISARMED or ARMED.

Reset
REQ-029 While RST = 1 at an edge, the block SHALL set STATE = DISARMED, ALARM = 0, SEC_LEFT = 0, ZONE = 0, TICK_10MS = 0, and clear the divider and timer.
REQ-030 Reset in any state, mid-delay included, SHALL give DISARMED on the same edge, and the divider SHALL restart at 0 after release.

Structure
REQ-031 Package security_pkg SHALL hold the state encodings, the KEY_ARM and KEY_DISARM codes and the constant TICKS_PER_SEC = 100.
REQ-032 The divider SHALL be a sub-module named tick_gen, with parameter TICK_DIV and ports CLK, RST, TICK.
REQ-033 The FSM, timer and output registers SHALL reside in security_timer_ctrl.

Verification (TICK_DIV=4, EXIT_SEC=2, ENTRY_SEC=3, ALARM_SEC=4)
REQ-034 Reset test: hold RST for 2 cycles -> STATE = 000, ALARM = 0, SEC_LEFT = 0, ZONE = 00, TICK_10MS period = 4 cycles after release.
REQ-035 Arm test: drive KEY = 11 for one cycle -> STATE = 001 and SEC_LEFT = 2 next cycle; SEC_LEFT = 1 after 100 ticks; STATE = 010 after 200 ticks (800 cycles, within 4 cycles).
REQ-036 Trip test: in ARMED drive SENSOR = 10 -> STATE = 011, ZONE = 10, SEC_LEFT = 3; then drive SENSOR = 01 -> ZONE = 11; after 300 ticks -> STATE = 100, ALARM = 1, SEC_LEFT = 4.
REQ-037 Disarm test: drive KEY = 00 in ENTRY_DLY at SEC_LEFT = 1 -> STATE = 000 next cycle, ALARM stays 0, ZONE = 00.
REQ-038 Collision test: drive KEY = 00 on the entry-expire cycle -> STATE = 100; in ARMED drive SENSOR = 01 together with KEY = 00 -> STATE = 011.
REQ-039 Timeout and reset test: hold KEY = 01 in ALARM_ST -> after 400 ticks STATE = 010, ALARM = 0, ZONE held; assert RST mid-EXIT_DLY -> STATE = 000 on that edge.
